seq_muldiv: RTL and testbench

- Multi-cycle unsigned 32x32 multiply and 32/32 divide unit in the execute stage.
- Sits directly upstream of adder32 and owns its operand inputs (add_a, add_b, add_cin).
- Consumes the adder's Result and Cout once per cycle, one iteration per clock: shift-add for multiply, restoring subtract for divide.
- Reuses the existing ripple adder; no second 32-bit adder is built.

---
 rtl/seq_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_seq_muldiv.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv
//
// Multi-cycle unsigned 32x32 multiply and 32/32 divide unit for the execute
// stage. It has no adder of its own. It drives the operands of the shared
// ripple adder (adder32) and takes back that adder's result and carry-out
// once per clock. Each clock performs one iteration: shift-add for
// multiply, or one restoring subtract step for divide.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   op         0 = unsigned multiply, 1 = unsigned divide
//   a          multiplicand / dividend
//   b          multiplier / divisor
//   add_a      operand A to adder32
//   add_b      operand B to adder32
//   add_cin    carry-in to adder32
//   add_result adder32 sum
//   add_cout   adder32 carry-out
//   busy       high while iterating
//   done       one-cycle completion pulse
//   div_zero   last divide had b == 0, held until the next accepted start
//   res_hi     multiply: product[63:32], divide: remainder
//   res_lo     multiply: product[31:0],  divide: quotient
// ---------------------------------------------------------------------------
module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] rem_shift;
    logic             take;

    // The divide step works on the partial remainder shifted left by one.
    // The next dividend bit enters from the top of lo. The bit shifted out of
    // hi[31] is the 33rd bit of that shifted value. When that bit is set, the
    // value is at least 2^32 and therefore at least d, so the subtract is
    // taken even if the 32-bit adder does not produce a carry.
    assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign take      = hi[WIDTH-1] | add_cout;

    // Adder operand steering. Multiply adds the multiplicand to the upper
    // half. Divide subtracts the divisor by adding its complement with a
    // carry-in of one. Outside RUN all drives are held at zero, so the
    // shared adder does not toggle when this unit is not using it.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            if (op_q) begin
                add_a   = rem_shift;
                add_b   = ~d;
                add_cin = 1'b1;
            end else begin
                add_a   = hi;
                add_b   = d;
                add_cin = 1'b0;
            end
        end
    end

    // Control and datapath sequencing. A start request in IDLE latches the
    // divisor/multiplier and sets up hi/lo. A divide by zero finishes at once
    // with the conventional all-ones quotient and the dividend as remainder.
    // RUN performs exactly ITER iterations and then passes through DONE for
    // one cycle, which produces the done pulse. Requests arriving in RUN or
    // DONE are dropped. A reset at any point abandons the operation without
    // a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            d          <= '0;
            hi         <= '0;
            lo         <= '0;
            count      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q       <= op;
                        d          <= b;
                        count      <= '0;
                        div_zero_q <= op && (b == '0);
                        if (op && (b == '0)) begin
                            hi     <= a;
                            lo     <= '1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            hi     <= '0;
                            lo     <= a;
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (!op_q) begin
                        if (lo[0]) begin
                            {hi, lo} <= {add_cout, add_result, lo[WIDTH-1:1]};
                        end else begin
                            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                        end
                    end else begin
                        hi <= take ? add_result : rem_shift;
                        lo <= {lo[WIDTH-2:0], take};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // The working registers also serve as the result registers. They hold
    // from the done cycle until the next accepted start.
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign res_hi   = hi;
    assign res_lo   = lo;

endmodule

// File: tb/tb_seq_muldiv.sv
// ---------------------------------------------------------------------------
// tb_seq_muldiv
//
// Self-checking bench for seq_muldiv. A behavioural model of adder32 closes
// the loop. Each accepted request pushes its expected result onto a
// scoreboard. A monitor pops an entry on every done pulse and compares it.
// The monitor also checks the adder drives on every cycle.
// ---------------------------------------------------------------------------
module tb_seq_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_result;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    logic        cur_op = 1'b0;
    logic [31:0] cur_b  = 32'h0;

    seq_muldiv #(.WIDTH(32), .ITER(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_result (add_result),
        .add_cout   (add_cout),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    // Behavioural stand-in for the shared ripple adder.
    assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_cin};

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    // Reference results computed with plain arithmetic.
    function automatic exp_t model(input logic o, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [63:0] p;
        e.acc = 0;
        if (!o) begin
            p     = {32'h0, av} * {32'h0, bv};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dz  = 1'b0;
            e.lat = 33;
        end else if (bv == 32'h0) begin
            e.hi  = av;
            e.lo  = 32'hFFFFFFFF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.lo  = av / bv;
            e.hi  = av % bv;
            e.dz  = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    // Monitor: checks results on each done pulse and the adder drives on
    // every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("res_hi", {32'h0, res_hi}, {32'h0, e.hi});
                    checkOutput("res_lo", {32'h0, res_lo}, {32'h0, e.lo});
                    checkOutput("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
                    checkOutput("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                    checkOutput("busy_at_done", {63'h0, busy}, 64'd0);
                end
            end
            if (busy) begin
                checkOutput("run_add_cin", {63'h0, add_cin}, {63'h0, cur_op});
                checkOutput("run_add_b", {32'h0, add_b}, {32'h0, cur_op ? ~cur_b : cur_b});
            end else begin
                checkOutput("idle_add_a", {32'h0, add_a}, 64'd0);
                checkOutput("idle_add_b", {32'h0, add_b}, 64'd0);
                checkOutput("idle_add_cin", {63'h0, add_cin}, 64'd0);
            end
        end
    end

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    // Wait until the unit is idle, present one request for one edge and
    // push the expected result onto the scoreboard.
    task automatic applyStimulus(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                 input bit wait_done);
        exp_t e;
        bit   idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
        start  = 1'b1;
        op     = o;
        a      = av;
        b      = bv;
        cur_op = o;
        cur_b  = bv;
        @(posedge clk);
        #1;
        e     = model(o, av, bv);
        e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (wait_done) waitDone();
    endtask

    initial begin
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        #12;
        checkOutput("reset_busy", {63'h0, busy}, 64'd0);
        checkOutput("reset_done", {63'h0, done}, 64'd0);
        checkOutput("reset_div_zero", {63'h0, div_zero}, 64'd0);
        checkOutput("reset_res", {res_hi, res_lo}, 64'd0);
        checkOutput("reset_add", {31'h0, add_cin, add_a ^ add_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        applyStimulus(1'b1, 32'd100, 32'd7, 1'b1);
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        applyStimulus(1'b1, 32'h12345678, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'd3, 32'd5, 1'b1);

        // A request while iterating must be dropped.
        applyStimulus(1'b0, 32'd6, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'hDEADBEEF;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("ignored_start_queue", 64'(sb.size()), 64'd0);

        // Reset in the middle of a divide.
        applyStimulus(1'b1, 32'hCAFEF00D, 32'd13, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {63'h0, busy}, 64'd0);
        checkOutput("midreset_done", {63'h0, done}, 64'd0);
        checkOutput("midreset_div_zero", {63'h0, div_zero}, 64'd0);
        checkOutput("midreset_res", {res_hi, res_lo}, 64'd0);
        checkOutput("midreset_add_a", {32'h0, add_a}, 64'd0);
        checkOutput("midreset_add_b", {32'h0, add_b}, 64'd0);
        checkOutput("midreset_add_cin", {63'h0, add_cin}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h12345, 1'b1);

        // Randomised traffic with biased divisors.
        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            applyStimulus(ro, ra, rb, 1'b1);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
